// File: rtl/vga_pkg.sv
// Shared VGA constants for the layer mixer slice.
//   RGB_W      packed {r,g,b} width
//   CNT_W      hcount/vcount width
//   CH_W       width of one colour channel
//   *_LSB      bit position of each channel inside a packed pixel
//   RGB_BLACK  all-zero pixel
package vga_pkg;
    localparam int unsigned RGB_W = 12;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned CH_W  = 4;
    localparam int unsigned R_LSB = 8;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned B_LSB = 0;
    localparam logic [RGB_W-1:0] RGB_BLACK = '0;
endpackage

// File: rtl/vga_layer_mixer_if.sv
// Pixel bus of the layer mixer: timing strobes, layer data in, mixed pixel
// and overlap statistics out.
//   master : video source side (drives *_in, rgb_in, opaque_in, layer_en_in, bg_rgb)
//   slave  : mixer side (drives *_out, hs, vs, r, g, b, overlap_cnt, collision, frame_tick)
interface vga_layer_mixer_if #(
    parameter int unsigned N_LAYERS = 4,
    parameter int unsigned RGB_W    = 12,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned OVL_W    = 16
);
    import vga_pkg::*;

    logic [CNT_W-1:0]          hcount_in;
    logic [CNT_W-1:0]          vcount_in;
    logic                      hsync_in;
    logic                      vsync_in;
    logic                      hblnk_in;
    logic                      vblnk_in;
    logic [N_LAYERS*RGB_W-1:0] rgb_in;
    logic [N_LAYERS-1:0]       opaque_in;
    logic [N_LAYERS-1:0]       layer_en_in;
    logic [RGB_W-1:0]          bg_rgb;

    logic [CNT_W-1:0]          hcount_out;
    logic [CNT_W-1:0]          vcount_out;
    logic                      hs;
    logic                      vs;
    logic [CH_W-1:0]           r;
    logic [CH_W-1:0]           g;
    logic [CH_W-1:0]           b;
    logic [OVL_W-1:0]          overlap_cnt;
    logic                      collision;
    logic                      frame_tick;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
               rgb_in, opaque_in, layer_en_in, bg_rgb,
        input  hcount_out, vcount_out, hs, vs, r, g, b,
               overlap_cnt, collision, frame_tick
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
               rgb_in, opaque_in, layer_en_in, bg_rgb,
        output hcount_out, vcount_out, hs, vs, r, g, b,
               overlap_cnt, collision, frame_tick
    );
endinterface

// File: rtl/vga_priority_encoder.sv
// Combinational highest-index-wins priority encoder.
//   req     : request bits, one per layer
//   idx_c   : index of the highest set request bit (0 when none)
//   valid_c : at least one request bit set
module vga_priority_encoder #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);
    // Ascending scan: later (higher) hits overwrite earlier ones.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (req[k]) begin
                idx_c   = IDX_W'(k);
                valid_c = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_layer_mixer.sv
// Two-stage VGA layer mixer with per-frame overlap statistics.
//   pclk, rst : pixel clock, synchronous active-high reset
//   bus       : vga_layer_mixer_if.slave -- timing/layer inputs, delayed
//               timing, mixed r/g/b, overlap_cnt, collision, frame_tick
// Stage 1 registers inputs and the winning layer; stage 2 selects the colour.
module vga_layer_mixer #(
    parameter int unsigned N_LAYERS = 4,
    parameter int unsigned RGB_W    = 12,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned OVL_W    = 16
) (
    input logic              pclk,
    input logic              rst,
    vga_layer_mixer_if.slave bus
);
    import vga_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_LAYERS);

    logic [N_LAYERS-1:0] active_mask;
    logic                vs_prev;
    logic [OVL_W-1:0]    acc;

    logic [CNT_W-1:0]    hcount_s1, vcount_s1;
    logic                hs_s1, vs_s1, blank_s1;
    logic [RGB_W-1:0]    layer_rgb_s1 [N_LAYERS];
    logic [RGB_W-1:0]    bg_s1;
    logic [IDX_W-1:0]    win_idx_s1;
    logic                win_vld_s1;
    logic                tick_s1, coll_s1;
    logic [OVL_W-1:0]    ovl_s1;

    logic                vs_rise_c, blank_c, overlap_c, win_vld_c;
    logic [N_LAYERS-1:0] eff_mask_c, act_c;
    logic [IDX_W-1:0]    win_idx_c;
    logic [RGB_W-1:0]    pix_c;

    // On the vsync rising edge the freshly requested enables already apply.
    assign vs_rise_c  = bus.vsync_in & ~vs_prev;
    assign eff_mask_c = vs_rise_c ? bus.layer_en_in : active_mask;
    assign act_c      = bus.opaque_in & eff_mask_c;
    assign blank_c    = bus.hblnk_in | bus.vblnk_in;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign overlap_c  = ~blank_c & ((act_c & (act_c - N_LAYERS'(1))) != '0);

    vga_priority_encoder #(
        .N     (N_LAYERS),
        .IDX_W (IDX_W)
    ) u_prio (
        .req     (act_c),
        .idx_c   (win_idx_c),
        .valid_c (win_vld_c)
    );

    // Stage 1: input capture, winner, mask, accumulator and frame snapshot.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_s1   <= '0;
            vcount_s1   <= '0;
            hs_s1       <= 1'b0;
            vs_s1       <= 1'b0;
            blank_s1    <= 1'b0;
            bg_s1       <= '0;
            win_idx_s1  <= '0;
            win_vld_s1  <= 1'b0;
            tick_s1     <= 1'b0;
            coll_s1     <= 1'b0;
            ovl_s1      <= '0;
            acc         <= '0;
            active_mask <= '1;
            vs_prev     <= 1'b1;
            for (int k = 0; k < int'(N_LAYERS); k++) layer_rgb_s1[k] <= '0;
        end else begin
            hcount_s1  <= bus.hcount_in;
            vcount_s1  <= bus.vcount_in;
            hs_s1      <= bus.hsync_in;
            vs_s1      <= bus.vsync_in;
            blank_s1   <= blank_c;
            bg_s1      <= bus.bg_rgb;
            win_idx_s1 <= win_idx_c;
            win_vld_s1 <= win_vld_c;
            tick_s1    <= vs_rise_c;
            vs_prev    <= bus.vsync_in;
            for (int k = 0; k < int'(N_LAYERS); k++)
                layer_rgb_s1[k] <= bus.rgb_in[k*RGB_W +: RGB_W];
            if (vs_rise_c) begin
                active_mask <= bus.layer_en_in;
                ovl_s1      <= acc;
                coll_s1     <= |acc;
                acc         <= '0;
            end else if (overlap_c && (acc != '1)) begin
                acc <= acc + OVL_W'(1);
            end
        end
    end

    always_comb begin
        pix_c = bg_s1;
        if (blank_s1)        pix_c = RGB_W'(RGB_BLACK);
        else if (win_vld_s1) pix_c = layer_rgb_s1[win_idx_s1];
    end

    // Stage 2: output registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            bus.hcount_out  <= '0;
            bus.vcount_out  <= '0;
            bus.hs          <= 1'b0;
            bus.vs          <= 1'b0;
            bus.r           <= '0;
            bus.g           <= '0;
            bus.b           <= '0;
            bus.frame_tick  <= 1'b0;
            bus.overlap_cnt <= '0;
            bus.collision   <= 1'b0;
        end else begin
            bus.hcount_out <= hcount_s1;
            bus.vcount_out <= vcount_s1;
            bus.hs         <= hs_s1;
            bus.vs         <= vs_s1;
            bus.r          <= pix_c[R_LSB +: CH_W];
            bus.g          <= pix_c[G_LSB +: CH_W];
            bus.b          <= pix_c[B_LSB +: CH_W];
            bus.frame_tick <= tick_s1;
            if (tick_s1) begin
                bus.overlap_cnt <= ovl_s1;
                bus.collision   <= coll_s1;
            end
        end
    end
endmodule

// File: tb/tb_vga_layer_mixer.sv
// Scoreboard bench for vga_layer_mixer: two instances (16-bit and 4-bit
// overlap counters) share one stimulus stream; a frame-level reference model
// pushes expected outputs, a monitor pops and compares them.
module tb_vga_layer_mixer;
    localparam int unsigned NL = 4;

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    vga_layer_mixer_if #(.N_LAYERS(NL), .RGB_W(12), .CNT_W(11), .OVL_W(16)) bus_a ();
    vga_layer_mixer_if #(.N_LAYERS(NL), .RGB_W(12), .CNT_W(11), .OVL_W(4))  bus_b ();

    assign bus_b.hcount_in   = bus_a.hcount_in;
    assign bus_b.vcount_in   = bus_a.vcount_in;
    assign bus_b.hsync_in    = bus_a.hsync_in;
    assign bus_b.vsync_in    = bus_a.vsync_in;
    assign bus_b.hblnk_in    = bus_a.hblnk_in;
    assign bus_b.vblnk_in    = bus_a.vblnk_in;
    assign bus_b.rgb_in      = bus_a.rgb_in;
    assign bus_b.opaque_in   = bus_a.opaque_in;
    assign bus_b.layer_en_in = bus_a.layer_en_in;
    assign bus_b.bg_rgb      = bus_a.bg_rgb;

    vga_layer_mixer #(.N_LAYERS(NL), .RGB_W(12), .CNT_W(11), .OVL_W(16)) dut_a (
        .pclk (pclk), .rst (rst), .bus (bus_a.slave));
    vga_layer_mixer #(.N_LAYERS(NL), .RGB_W(12), .CNT_W(11), .OVL_W(4)) dut_b (
        .pclk (pclk), .rst (rst), .bus (bus_b.slave));

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        tick;
        int          ovl;   // unsaturated count; each instance saturates on compare
        logic        coll;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Stimulus state (applied at the next step)
    logic        s_rst = 1'b1;
    logic [10:0] s_hc = '0, s_vc = '0;
    logic        s_hs = 1'b0, s_vsync = 1'b1, s_hb = 1'b1, s_vb = 1'b1;
    logic [47:0] s_rgb = '0;
    logic [3:0]  s_opq = '0, s_en = '1;
    logic [11:0] s_bg = '0;

    // Reference model state
    logic [3:0]  m_mask = '1;
    logic        m_prev = 1'b1;
    int          m_acc = 0, m_ovl = 0;
    logic        m_coll = 1'b0;

    function automatic exp_t zero_exp();
        exp_t z;
        z.hc = '0; z.vc = '0; z.hs = 1'b0; z.vs = 1'b0; z.rgb = '0;
        z.tick = 1'b0; z.ovl = 0; z.coll = 1'b0;
        return z;
    endfunction

    // Drive one pixel and predict what appears two cycles later.
    task automatic step();
        exp_t        e;
        logic        rise, blank, found;
        logic [3:0]  emask, act;
        logic [47:0] layers;
        @(negedge pclk);
        rst               = s_rst;
        bus_a.hcount_in   = s_hc;
        bus_a.vcount_in   = s_vc;
        bus_a.hsync_in    = s_hs;
        bus_a.vsync_in    = s_vsync;
        bus_a.hblnk_in    = s_hb;
        bus_a.vblnk_in    = s_vb;
        bus_a.rgb_in      = s_rgb;
        bus_a.opaque_in   = s_opq;
        bus_a.layer_en_in = s_en;
        bus_a.bg_rgb      = s_bg;
        if (s_rst) begin
            // Reset also clears the output stage, so the pixel still in flight is lost.
            if (sb.size() > 0) sb[sb.size()-1] = zero_exp();
            sb.push_back(zero_exp());
            m_mask = '1; m_prev = 1'b1; m_acc = 0; m_ovl = 0; m_coll = 1'b0;
        end else begin
            rise   = s_vsync && !m_prev;
            emask  = rise ? s_en : m_mask;
            act    = s_opq & emask;
            blank  = s_hb || s_vb;
            layers = s_rgb;
            e.hc = s_hc; e.vc = s_vc; e.hs = s_hs; e.vs = s_vsync;
            e.rgb = s_bg;
            found = 1'b0;
            for (int k = NL - 1; k >= 0; k--) begin
                if (!found && act[k]) begin
                    e.rgb = layers[k*12 +: 12];
                    found = 1'b1;
                end
            end
            if (blank) e.rgb = '0;
            if (rise) begin
                m_ovl = m_acc; m_coll = (m_acc != 0); m_acc = 0; m_mask = s_en;
            end else if (!blank && $countones(act) >= 2) begin
                m_acc++;
            end
            m_prev = s_vsync;
            e.tick = rise; e.ovl = m_ovl; e.coll = m_coll;
            sb.push_back(e);
        end
        s_hc = s_hc + 11'd1;
        s_hs = (s_hc[5:3] == 3'd0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: output for the pixel applied two steps ago is visible now.
    always @(posedge pclk) begin
        exp_t e;
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            n_vec++;
            chk("pix_a",  64'({bus_a.r, bus_a.g, bus_a.b}), 64'(e.rgb));
            chk("pix_b",  64'({bus_b.r, bus_b.g, bus_b.b}), 64'(e.rgb));
            chk("timing", 64'({bus_a.hcount_out, bus_a.vcount_out, bus_a.hs, bus_a.vs}),
                          64'({e.hc, e.vc, e.hs, e.vs}));
            chk("tick_a", 64'({bus_a.frame_tick, bus_a.collision}), 64'({e.tick, e.coll}));
            chk("tick_b", 64'({bus_b.frame_tick, bus_b.collision}), 64'({e.tick, e.coll}));
            chk("ovl16",  64'(bus_a.overlap_cnt), 64'((e.ovl > 65535) ? 65535 : e.ovl));
            chk("ovl4",   64'(bus_b.overlap_cnt), 64'((e.ovl > 15) ? 15 : e.ovl));
        end
    end

    task automatic vsync_pulse(input int len);
        s_hb = 1'b1; s_vb = 1'b1; s_vsync = 1'b1;
        repeat (len) step();
        s_vsync = 1'b0;
        repeat (2) step();
        s_hb = 1'b0; s_vb = 1'b0;
        s_vc = s_vc + 11'd1;
    endtask

    // Active frame with exactly n_ovl overlapping pixels under mask 4'b1011.
    task automatic counted_frame(input int n_ovl);
        for (int i = 0; i < n_ovl + 25; i++) begin
            s_opq = (i < n_ovl) ? 4'b0011 : 4'b0001;
            step();
        end
    endtask

    task automatic random_frame(input int n);
        for (int i = 0; i < n; i++) begin
            s_opq = 4'($urandom());
            s_rgb = 48'({$urandom(), $urandom()});
            s_bg  = 12'($urandom());
            s_hb  = ($urandom_range(0, 3) == 0);
            s_vb  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) s_en = 4'($urandom());
            step();
        end
        s_hb = 1'b0; s_vb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset with vsync already high; release while it stays high.
        repeat (3) step();
        s_rst = 1'b0;
        repeat (4) step();
        s_vsync = 1'b0;
        repeat (2) step();
        s_hb = 1'b0; s_vb = 1'b0;

        // Layer 2 (F00) beats layer 1 (0F0); blanking forces black.
        s_rgb = {12'h00F, 12'hF00, 12'h0F0, 12'h00A};
        s_opq = 4'b0110;
        s_bg  = 12'h123;
        repeat (4) step();
        s_hb = 1'b1; step();
        s_hb = 1'b0; repeat (2) step();

        // Mid-frame enable change is deferred to the next vsync rise.
        s_en = 4'b1011;
        repeat (5) step();
        vsync_pulse(3);
        s_opq = 4'b0110;
        repeat (5) step();
        s_opq = 4'b0000;
        repeat (2) step();

        // Exact counts: 37, 0, 20 (saturates in 4-bit), 0.
        vsync_pulse(1);
        counted_frame(37); vsync_pulse(3);
        counted_frame(0);  vsync_pulse(2);
        counted_frame(20); vsync_pulse(1);
        counted_frame(0);  vsync_pulse(4);

        // Randomised frames with mask changes and varied vsync widths.
        s_en = 4'b1111;
        for (int f = 0; f < 6; f++) begin
            random_frame(150 + int'($urandom_range(0, 100)));
            vsync_pulse(int'($urandom_range(1, 4)));
        end

        // Reset mid-frame with vsync held high throughout.
        random_frame(40);
        s_vsync = 1'b1;
        repeat (2) step();
        s_rst = 1'b1;
        repeat (2) step();
        s_rst = 1'b0;
        s_en = 4'b0101;
        repeat (5) step();
        s_vsync = 1'b0;
        random_frame(60);
        vsync_pulse(2);
        random_frame(30);

        s_opq = '0;
        repeat (3) step();
        @(posedge pclk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_layer_mixer.md
VGA_LAYER_MIXER -- requirements
Module: vga_layer_mixer

Interface
REQ-001 Parameter N_LAYERS, default 4, number of RGB layer channels; legal range 2..8.
REQ-002 Parameter RGB_W, default 12, packed {r,g,b} width, 4 bits per colour.
REQ-003 Parameter CNT_W, default 11, width of hcount/vcount.
REQ-004 Parameter OVL_W, default 16, width of the overlap counter.
REQ-005 Port pclk, input, 1, pixel clock; the only clock.
REQ-006 Port rst, input, 1, reset, synchronous, active-high.
REQ-007 Ports hcount_in/vcount_in, input, CNT_W each, pixel position.
REQ-008 Ports hsync_in/vsync_in/hblnk_in/vblnk_in, input, 1 each, timing strobes, active-high.
REQ-009 Port rgb_in, input, N_LAYERS*RGB_W, layer k occupies bits [k*RGB_W +: RGB_W].
REQ-010 Port opaque_in, input, N_LAYERS, bit k set = layer k drives the current pixel.
REQ-011 Port layer_en_in, input, N_LAYERS, requested layer enable mask.
REQ-012 Port bg_rgb, input, RGB_W, colour used when no enabled layer is opaque.
REQ-013 Ports hcount_out/vcount_out, output, CNT_W each, delayed position.
REQ-014 Ports hs/vs, output, 1 each, delayed hsync/vsync.
REQ-015 Ports r/g/b, output, 4 each, mixed pixel colour.
REQ-016 Port overlap_cnt, output, OVL_W, overlap pixel count of the last completed frame.
REQ-017 Port collision, output, 1, set when overlap_cnt is non-zero.
REQ-018 Port frame_tick, output, 1, one-cycle pulse when overlap_cnt and collision update.

Function
REQ-019 Fixed latency of 2 pclk cycles from every input to its corresponding output; hcount/vcount/hs/vs stay aligned with r/g/b.
REQ-020 Stage 1 registers all inputs and computes the winning layer.
- Winner = highest index k with opaque_in[k] & active_mask[k].
REQ-021 Stage 2 selects the winning layer's rgb, or bg_rgb if there is no winner; output = {r,g,b}.
REQ-022 If hblnk or vblnk is high at stage 1, r/g/b SHALL be 0 regardless of layers.
REQ-023 active_mask SHALL load layer_en_in on the stage-1 vsync rising edge (vsync_in high now, low in the previous cycle) and hold for the rest of the frame.
- Changes to layer_en_in mid-frame have no visible effect until the next rising edge.
REQ-024 If layer_en_in changes on the same cycle as the vsync rising edge, the new value SHALL be captured.
REQ-025 Overlap pixel: not blanked, and at least two bits of (opaque_in & active_mask) are set.
REQ-026 The internal accumulator SHALL increment once per overlap pixel and saturate at 2^OVL_W-1 with no wrap.
REQ-027 On each vsync rising edge:
- overlap_cnt <= accumulator, or the saturated value.
- collision <= (accumulator != 0).
- accumulator <= 0; an overlap pixel on that same cycle SHALL NOT be counted.
- frame_tick pulses high for exactly one cycle, aligned with the overlap_cnt update.
REQ-028 A vsync_in held high for several cycles SHALL produce exactly one frame_tick.

Reset
REQ-029 While rst is high at a pclk edge, the following SHALL be 0: all pipeline registers, hs, vs, r, g, b, hcount_out, vcount_out, overlap_cnt, collision, frame_tick and the accumulator.
REQ-030 On reset, active_mask SHALL become all-ones.
REQ-031 The vsync edge detector SHALL reset to "previous = 1", so that a vsync_in already high at reset release does not generate a frame_tick.
REQ-032 Reset mid-frame: the first 2 cycles after release SHALL output black; normal mixing resumes afterwards, and counting restarts from 0.

Structure
REQ-033 The shared package/header vga_pkg SHALL hold RGB_W, CNT_W, the RGB_BLACK constant and the 4-bit channel slice widths.
REQ-034 The winner logic SHALL be one sub-module, vga_priority_encoder (N_LAYERS-bit request in; index and valid out; combinational).
- All storage stays in vga_layer_mixer.

Verification
REQ-035 N_LAYERS=4, mask=4'b1111, layer2 opaque (rgb 12'hF00) and layer1 opaque (12'h0F0), active area -> output 12'hF00 two cycles later.
REQ-036 Same pixel with hblnk_in=1 -> output 12'h000; hcount_out equals the hcount_in from 2 cycles earlier.
REQ-037 Apply layer_en_in=4'b1011 mid-frame while layer2 wins -> still 12'hF00 until the next vsync rising edge, then 12'h0F0.
REQ-038 Frame with exactly 37 overlap pixels -> at the next vsync rising edge, frame_tick pulses once, overlap_cnt=37 and collision=1; the following frame with 0 overlaps gives overlap_cnt=0 and collision=0.
REQ-039 OVL_W=4 and 20 overlap pixels -> overlap_cnt=15, with no wrap.
REQ-040 Assert rst mid-frame with vsync_in held high -> outputs 0, active_mask=all-ones, and no frame_tick until a fresh low-to-high vsync transition.
